// File: rtl/uart_tx_controller_if.sv
// rtl/uart_tx_controller_if.sv - register-store bus and serial outputs of the UART transmit controller
interface uart_tx_controller_if;
    logic        wr_en;
    logic [1:0]  reg_sel;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        tx;
    logic        busy;

    modport master (
        output wr_en, reg_sel, wr_data,
        input  rd_data, tx, busy
    );

    modport slave (
        input  wr_en, reg_sel, wr_data,
        output rd_data, tx, busy
    );
endinterface

// File: rtl/uart_tx_controller.sv
// rtl/uart_tx_controller.sv - memory-mapped UART TX: byte FIFO, baud divisor, 8N1 serialiser
// Optional even parity bit when UART_PARITY_EN is defined.
module uart_tx_controller #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int DIV_DEFAULT = 434
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_controller_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic [DIV_WIDTH-1:0] baud_div_q, div_lat_q, div_eff, cnt_q, cnt_d;
    logic [7:0]           sh_q;
    logic [2:0]           bit_q, bit_d;
    logic                 tx_q, tx_d, busy_q, overflow_q;
    logic                 pop, push, drop, full, empty;
    logic                 wr_tx, wr_stat, wr_baud;
    logic                 unused_wr_bits;

    assign unused_wr_bits = ^bus.wr_data[31:DIV_WIDTH];

    assign wr_tx   = bus.wr_en && (bus.reg_sel == 2'b01);
    assign wr_stat = bus.wr_en && (bus.reg_sel == 2'b10);
    assign wr_baud = bus.wr_en && (bus.reg_sel == 2'b11);

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign push    = wr_tx && (!full || pop);
    assign drop    = wr_tx && full && !pop;
    assign count_d = count_q + CW'(push) - CW'(pop);
    assign div_eff = (baud_div_q == '0) ? DIV_WIDTH'(1) : baud_div_q;

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        if (state_q == S_IDLE) begin
            tx_d = 1'b1;
            if (!empty) begin
                pop     = 1'b1;
                state_d = S_START;
                tx_d    = 1'b0;
                cnt_d   = div_eff - DIV_WIDTH'(1);
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
        end else begin
            // Bit period elapsed: reload with the divisor latched at pop.
            cnt_d = div_lat_q - DIV_WIDTH'(1);
            if (state_q == S_START) begin
                state_d = S_DATA;
                bit_d   = 3'd0;
                tx_d    = sh_q[0];
            end else if (state_q == S_DATA) begin
                if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                    state_d = S_PARITY;
                    tx_d    = ^sh_q;
`else
                    state_d = S_STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    bit_d = bit_q + 3'd1;
                    tx_d  = sh_q[bit_q + 3'd1];
                end
            end else if (state_q == S_PARITY) begin
                state_d = S_STOP;
                tx_d    = 1'b1;
            end else begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            sh_q       <= 8'h00;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            baud_div_q <= DIV_WIDTH'(DIV_DEFAULT);
            div_lat_q  <= DIV_WIDTH'(DIV_DEFAULT);
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            count_q <= count_d;
            busy_q  <= (state_d != S_IDLE) || (count_d != '0);
            if (pop) begin
                sh_q      <= mem_q[rd_ptr_q];
                div_lat_q <= div_eff;
                rd_ptr_q  <= rd_ptr_q + PW'(1);
            end
            if (push) begin
                mem_q[wr_ptr_q] <= bus.wr_data[7:0];
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (wr_stat && bus.wr_data[0]) begin
                overflow_q <= 1'b0;
            end
            if (wr_baud) begin
                baud_div_q <= bus.wr_data[DIV_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        case (bus.reg_sel)
            2'b10:   bus.rd_data = {28'b0, overflow_q, full, empty, busy_q};
            2'b11:   bus.rd_data = 32'(baud_div_q);
            default: bus.rd_data = 32'h0;
        endcase
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb/tb_uart_tx_controller.sv - self-checking bench for uart_tx_controller with frame-level model
module tb_uart_tx_controller;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   cyc;
    bit   cmp_en;

    uart_tx_controller_if bus();

    uart_tx_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: each pop builds the full bit vector, tx is indexed by elapsed time.
    logic [7:0]  m_q[$];
    bit          m_act;
    int          m_pos, m_div, m_baud, m_sz;
    bit          m_pop, m_ovf;
    logic [10:0] m_frame;
    logic [7:0]  m_b;
    logic        m_tx;
    logic        m_busy;

    initial begin
        m_tx = 1'b1;
        m_busy = 1'b0;
        m_baud = 434;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_act  = 0;
            m_ovf  = 0;
            m_baud = 434;
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end else begin
            m_sz  = m_q.size();
            m_pop = !m_act && (m_sz > 0);
            if (m_act) begin
                m_pos++;
                if (m_pos == NB * m_div) m_act = 0;
            end else if (m_pop) begin
                m_b        = m_q.pop_front();
                m_frame    = '1;
                m_frame[0] = 1'b0;
                for (int k = 0; k < 8; k++) m_frame[k+1] = m_b[k];
`ifdef UART_PARITY_EN
                m_frame[9] = ^m_b;
`endif
                m_div = (m_baud == 0) ? 1 : m_baud;
                m_pos = 0;
                m_act = 1;
            end
            if (bus.wr_en && bus.reg_sel == 2'b01) begin
                if (m_sz < 4 || m_pop) m_q.push_back(bus.wr_data[7:0]);
                else m_ovf = 1;
            end
            if (bus.wr_en && bus.reg_sel == 2'b10 && bus.wr_data[0]) m_ovf = 0;
            if (bus.wr_en && bus.reg_sel == 2'b11) m_baud = int'(bus.wr_data[15:0]);
            m_tx   = m_act ? m_frame[m_pos / m_div] : 1'b1;
            m_busy = m_act || (m_q.size() > 0);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("tx_model", 32'(bus.tx), 32'(m_tx));
            chk("busy_model", 32'(bus.busy), 32'(m_busy));
        end
    end

    // Independent serial receiver, samples mid-bit with the divisor latched at the start edge.
    int         rx_div;
    int         rx_cur, rx_idx;
    bit         rx_on;
    logic [7:0] rx_sh;
    logic       rx_par;
    logic [7:0] rx_q[$];
    logic       par_q[$];
    int         fall_q[$];

    always @(negedge clk) begin
        if (reset) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (bus.tx == 1'b0) begin
                rx_on  = 1;
                rx_idx = 0;
                rx_cur = rx_div;
                fall_q.push_back(cyc);
            end
        end else begin
            rx_idx++;
            for (int k = 1; k <= 8; k++)
                if (rx_idx == k * rx_cur + rx_cur / 2) rx_sh[k-1] = bus.tx;
            if (NB == 11 && rx_idx == 9 * rx_cur + rx_cur / 2) rx_par = bus.tx;
            if (rx_idx == (NB - 1) * rx_cur + rx_cur / 2) begin
                chk("rx_stop", 32'(bus.tx), 32'd1);
                rx_q.push_back(rx_sh);
                par_q.push_back(rx_par);
                rx_on = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.reg_sel = sel;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
        bus.reg_sel = 2'b00;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] sel, input logic [31:0] exp);
        logic [31:0] v;
        bus.reg_sel = sel;
        #1;
        v = bus.rd_data;
        bus.reg_sel = 2'b00;
        chk(name, v, exp);
        if (sel == 2'b10)
            chk({name, "_model"}, v, {28'b0, m_ovf, m_q.size() == 4, m_q.size() == 0, m_busy});
    endtask

    task automatic wait_rx(input int n, input int lim);
        int t = 0;
        while (rx_q.size() < n && t < lim) begin
            tick();
            t++;
        end
        chk("rx_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_idle(input int lim, output int c);
        int t = 0;
        while (bus.busy && t < lim) begin
            tick();
            t++;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
        c = cyc;
    endtask

    logic [10:0] exp55;
    int          c_end, zeros;

    initial begin
        tests = 0;
        fails = 0;
        cmp_en = 0;
        rx_div = 4;
        reset = 1'b1;
        bus.wr_en = 1'b0;
        bus.reg_sel = 2'b00;
        bus.wr_data = 32'h0;

        // 1: reset
        tick();
        cmp_en = 1;
        tick();
        chk("rst_tx", 32'(bus.tx), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rd_chk("rst_status", 2'b10, 32'h2);
        rd_chk("rst_baud", 2'b11, 32'd434);
        rd_chk("rd_none", 2'b00, 32'h0);
        reset = 1'b0;
        tick();
        wr(2'b11, 32'd4);
        rd_chk("baud4", 2'b11, 32'd4);
        rd_chk("rd_txdata", 2'b01, 32'h0);

        // 2: single byte, literal waveform
        wr(2'b01, 32'h55);
        chk("pre_fall_tx", 32'(bus.tx), 32'd1);
        tick();
        exp55 = '1;
        exp55[8:0] = {8'h55, 1'b0};
`ifdef UART_PARITY_EN
        exp55[9] = 1'b0;
`endif
        for (int k = 0; k < NB * 4; k++) begin
            chk("w55_tx", 32'(bus.tx), 32'(exp55[k / 4]));
            chk("w55_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        chk("w55_done_busy", 32'(bus.busy), 32'd0);
        chk("w55_done_tx", 32'(bus.tx), 32'd1);
        wait_rx(1, 10);
        if (rx_q.size() > 0) chk("w55_rx", 32'(rx_q[0]), 32'h55);

        // 3: overflow and back-to-back frames
        rx_q.delete();
        fall_q.delete();
        bus.wr_en = 1'b1;
        bus.reg_sel = 2'b01;
        for (int i = 1; i <= 6; i++) begin
            bus.wr_data = 32'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        bus.reg_sel = 2'b00;
        rd_chk("ovf_status", 2'b10, 32'hD);
        wait_rx(5, 400);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("ovf_rx", 32'(rx_q[i]), 32'(i + 1));
        for (int i = 1; i < 5 && i < fall_q.size(); i++)
            chk("b2b_gap", 32'(fall_q[i] - fall_q[i-1]), 32'(NB * 4 + 1));
        wait_idle(100, c_end);
        rd_chk("ovf_sticky", 2'b10, 32'hA);
        wr(2'b10, 32'h1);
        rd_chk("ovf_clear", 2'b10, 32'h2);

        // 4: reset mid-frame with bytes queued
        rx_q.delete();
        bus.wr_en = 1'b1;
        bus.reg_sel = 2'b01;
        bus.wr_data = 32'hA5; tick();
        bus.wr_data = 32'hB1; tick();
        bus.wr_data = 32'hC2; tick();
        bus.wr_en = 1'b0;
        bus.reg_sel = 2'b00;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        chk("midrst_tx", 32'(bus.tx), 32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        rd_chk("midrst_status", 2'b10, 32'h2);
        rd_chk("midrst_baud", 2'b11, 32'd434);
        reset = 1'b0;
        zeros = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (bus.tx == 1'b0) zeros++;
        end
        chk("midrst_no_frame", 32'(zeros), 32'd0);
        chk("midrst_rx", 32'(rx_q.size()), 32'd0);
        wr(2'b11, 32'd4);

        // 5: divisor change mid-frame
        rx_q.delete();
        fall_q.delete();
        bus.wr_en = 1'b1;
        bus.reg_sel = 2'b01;
        bus.wr_data = 32'h3C; tick();
        bus.wr_data = 32'hC3; tick();
        bus.reg_sel = 2'b11;
        bus.wr_data = 32'd8; tick();
        bus.wr_en = 1'b0;
        bus.reg_sel = 2'b00;
        rx_div = 8;
        wait_rx(2, 400);
        if (rx_q.size() >= 2) begin
            chk("div_f1", 32'(rx_q[0]), 32'h3C);
            chk("div_f2", 32'(rx_q[1]), 32'hC3);
        end
        wait_idle(200, c_end);
        if (fall_q.size() >= 2) begin
            chk("div_gap", 32'(fall_q[1] - fall_q[0]), 32'(NB * 4 + 1));
            chk("div_f2_len", 32'(c_end - fall_q[1]), 32'(NB * 8));
        end

`ifdef UART_PARITY_EN
        // 6: parity
        wr(2'b11, 32'd4);
        rx_div = 4;
        rx_q.delete();
        fall_q.delete();
        wr(2'b01, 32'h07);
        wait_rx(1, 100);
        wait_idle(100, c_end);
        if (par_q.size() > 0) chk("par_07", 32'(par_q[par_q.size()-1]), 32'd1);
        if (fall_q.size() > 0) chk("par_len", 32'(c_end - fall_q[0]), 32'd44);
        wr(2'b01, 32'h03);
        wait_rx(2, 100);
        wait_idle(100, c_end);
        if (par_q.size() > 0) chk("par_03", 32'(par_q[par_q.size()-1]), 32'd0);
`endif

        // 7: divisor 0 behaves as 1
        wr(2'b11, 32'd0);
        rd_chk("baud0", 2'b11, 32'd0);
        rx_div = 1;
        rx_q.delete();
        fall_q.delete();
        wr(2'b01, 32'h5A);
        wait_rx(1, 40);
        wait_idle(40, c_end);
        if (rx_q.size() > 0) chk("div0_rx", 32'(rx_q[0]), 32'h5A);
        if (fall_q.size() > 0) chk("div0_len", 32'(c_end - fall_q[0]), 32'(NB));

        tick();
        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
